// File: rtl/cpu_control_unit.sv
// cpu_control_unit
//   Multi-cycle sequencer for the 8-bit Von Neumann CPU. A registered phase
//   (RESET/FETCH/DECODE/IMM/EXEC/HALT) together with the latched instruction
//   is decoded combinationally into every datapath control line.
//
// Optional build macro: CPU_INSTR_COUNT_EN
//   Adds the instret output, a saturating retired-instruction counter.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   irvalue    in   [7:4] op, [3:2] rd, [1:0] rs
//   zero       in   ALU zero flag (used in EXEC only)
//   negative   in   ALU negative flag (used in EXEC only)
//   irload     out  load IR from memory data bus
//   imload     out  load immediate register from memory data bus
//   pcsel      out  PC source: 0 = PC+1, 1 = imm
//   pcload     out  PC write enable
//   readwrite  out  memory direction: 0 = read, 1 = write
//   dwrite     out  register-file write enable
//   dregsel    out  destination / dbus register select
//   sregsel    out  source / sbus register select
//   aluop      out  00 ADD, 01 SUB, 10 AND, 11 OR
//   regsel     out  write data: 00 aluout, 01 imm, 10 datain, 11 sbus
//   addrsel    out  address: 00 PC, 01 imm, 10 sbus, 11 dbus
//   phase      out  current state encoding
//   halted     out  high in HALT
//   instret    out  retired-instruction count (CPU_INSTR_COUNT_EN only)
module cpu_control_unit #(
    parameter int unsigned STARTUP_CYCLES = 1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       irvalue,
    input  logic             zero,
    input  logic             negative,
    output logic             irload,
    output logic             imload,
    output logic             pcsel,
    output logic             pcload,
    output logic             readwrite,
    output logic             dwrite,
    output logic [1:0]       dregsel,
    output logic [1:0]       sregsel,
    output logic [1:0]       aluop,
    output logic [1:0]       regsel,
    output logic [1:0]       addrsel,
    output logic [2:0]       phase,
`ifdef CPU_INSTR_COUNT_EN
    output logic [CNT_W-1:0] instret,
`endif
    output logic             halted
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_IMM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_startup_cnt;
    logic        w_startup_done;
    logic [3:0]  w_op;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;

    assign w_op           = irvalue[7:4];
    assign w_rd           = irvalue[3:2];
    assign w_rs           = irvalue[1:0];
    assign w_startup_done = (r_startup_cnt == 4'(STARTUP_CYCLES));
    assign phase          = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RESET;
            r_startup_cnt <= '0;
        end else begin
            r_state <= w_next;
            // Counts edges spent in RESET; cleared whenever RESET is left so a
            // later re-entry (from an illegal encoding) waits the full time.
            if (r_state == ST_RESET && !w_startup_done)
                r_startup_cnt <= r_startup_cnt + 4'd1;
            else
                r_startup_cnt <= '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        irload    = 1'b0;
        imload    = 1'b0;
        pcsel     = 1'b0;
        pcload    = 1'b0;
        readwrite = 1'b0;
        dwrite    = 1'b0;
        dregsel   = 2'b00;
        sregsel   = 2'b00;
        aluop     = 2'b00;
        regsel    = 2'b00;
        addrsel   = 2'b00;
        halted    = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (w_startup_done) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                irload = 1'b1;
                pcload = 1'b1;
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    4'hF:                                    w_next = ST_HALT;
                    4'h4, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC: w_next = ST_IMM;
                    default:                                 w_next = ST_EXEC;
                endcase
            end
            ST_IMM: begin
                imload = 1'b1;
                pcload = 1'b1;
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_next = ST_FETCH;
                case (w_op)
                    4'h0, 4'h1, 4'h2, 4'h3: begin
                        aluop   = w_op[1:0];
                        dregsel = w_rd;
                        sregsel = w_rs;
                        dwrite  = 1'b1;
                    end
                    4'h4: begin
                        dregsel = w_rd;
                        regsel  = 2'b01;
                        dwrite  = 1'b1;
                    end
                    4'h5: begin
                        sregsel = w_rs;
                        addrsel = 2'b10;
                        regsel  = 2'b10;
                        dregsel = w_rd;
                        dwrite  = 1'b1;
                    end
                    4'h6: begin
                        sregsel   = w_rs;
                        dregsel   = w_rd;
                        addrsel   = 2'b10;
                        readwrite = 1'b1;
                    end
                    4'h7: begin
                        addrsel = 2'b01;
                        regsel  = 2'b10;
                        dregsel = w_rd;
                        dwrite  = 1'b1;
                    end
                    4'h8: begin
                        addrsel   = 2'b01;
                        dregsel   = w_rd;
                        readwrite = 1'b1;
                    end
                    4'h9: begin
                        pcsel  = 1'b1;
                        pcload = 1'b1;
                    end
                    4'hA: begin
                        pcsel  = 1'b1;
                        pcload = zero;
                    end
                    4'hB: begin
                        pcsel  = 1'b1;
                        pcload = ~zero;
                    end
                    4'hC: begin
                        pcsel  = 1'b1;
                        pcload = negative;
                    end
                    4'hD: begin
                        sregsel = w_rs;
                        dregsel = w_rd;
                        regsel  = 2'b11;
                        dwrite  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: w_next = ST_RESET;
        endcase
    end

`ifdef CPU_INSTR_COUNT_EN
    logic w_retire;
    assign w_retire = (r_state == ST_EXEC) ||
                      (r_state == ST_DECODE && w_op == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= '0;
        else if (w_retire && instret != '1)
            instret <= instret + 1'b1;
    end
`endif

endmodule
